twowire_dtm_bus_master: RTL and testbench
=========================================

Name: twowire_dtm_bus_master

Overview:
Downstream bus-access engine for the Two-Wire Debug DTM. It sits between the DTM core's architectural address/data registers and the APB3-style downstream port. It accepts single read/write requests from the core and runs APB setup/access phases with unlimited wait states. It returns read data and error status, and supplies the post-increment address when auto-increment is enabled.

Parameters:
ASIZE, 0, address size code; bus address width W_ADDR = 8*(1+ASIZE) bits

Ports:
dck  input  1  DTM clock; all logic on rising edge
drst  input  1  synchronous active-high reset
req_vld  input  1  request strobe from core, one cycle
req_write  input  1  1 = write, 0 = read; sampled with req_vld
req_addr  input  W_ADDR  bus address; sampled with req_vld
req_wdata  input  32  write data; sampled with req_vld
aincr  input  1  auto-increment enable (csr_aincr); sampled with req_vld
abort  input  1  disconnect/abandon: suppress result of in-flight transfer
busy  output  1  transfer in flight (state != IDLE)
busy_err  output  1  one-cycle pulse: req_vld seen while busy; request dropped
resp_vld  output  1  one-cycle pulse: transfer complete, result valid
resp_rdata  output  32  read data (held until next resp_vld)
resp_err  output  1  pslverr captured at completion; valid with resp_vld
addr_upd_vld  output  1  one-cycle pulse: core loads addr_upd into its address register
addr_upd  output  W_ADDR  incremented address
dst_paddr  output  W_ADDR  APB address
dst_psel  output  1  APB select
dst_penable  output  1  APB enable
dst_pwrite  output  1  APB direction
dst_pwdata  output  32  APB write data
dst_pready  input  1  APB ready
dst_pslverr  input  1  APB error
dst_prdata  input  32  APB read data

Behaviour:
- Reset (drst high at a dck edge): state=IDLE. All outputs 0: busy, busy_err, resp_vld, resp_err, addr_upd_vld, dst_psel, dst_penable, dst_pwrite, dst_paddr, dst_pwdata, resp_rdata, addr_upd. Internal abort_pend=0. Reset mid-transfer drops psel immediately. APB protocol violation at reset is accepted.
- States: IDLE, SETUP, ACCESS.
- IDLE: on req_vld, register addr/wdata/write/aincr, then go to SETUP. In the next cycle dst_psel=1, dst_penable=0, and address, data and direction are driven from registers.
- SETUP -> ACCESS unconditionally after one cycle. In ACCESS: dst_psel=1, dst_penable=1.
- ACCESS: stay while dst_pready=0; all APB outputs stay stable.
- When dst_pready=1 in ACCESS: capture prdata (reads only; resp_rdata unchanged on writes) and pslverr, then go to IDLE. psel and penable are 0 next cycle.
- Result pulses in the cycle after the pready=1 edge (same cycle state is IDLE):
  - resp_vld=1.
  - resp_err=pslverr.
  - addr_upd_vld=1 only if aincr && !pslverr.
- Latency, zero wait states: req_vld at cycle N -> SETUP N+1 -> ACCESS N+2 (pready=1) -> resp_vld N+3.
- busy=1 in SETUP and ACCESS only. busy=0 in the resp_vld cycle.
- A new req_vld in the resp_vld cycle is accepted (back-to-back, 3-cycle throughput).
- Address increment: addr_upd = (captured addr + 4) mod 2^W_ADDR. Wraps from all-ones region to 0. Low 2 bits are carried unchanged.
- req_vld while busy: request ignored, busy_err pulses the next cycle, in-flight transfer unaffected.
- abort while busy: set abort_pend. The APB transfer runs to completion, because APB cannot be abandoned. At completion, resp_vld, resp_err and addr_upd_vld are suppressed and resp_rdata is unchanged. abort_pend clears on return to IDLE.
- abort in IDLE: no effect.
- abort together with req_vld in IDLE: request dropped.
- dst_pwdata is driven only for writes; it is 0 during reads.
- dst_pslverr and dst_prdata are ignored outside an ACCESS cycle with pready=1.

Test Plan:
1. Reset, then write: req_write=1, addr=0x40, wdata=0xDEADBEEF, aincr=0, pready=1.
   -> SETUP then ACCESS with paddr=0x40, pwrite=1, pwdata=0xDEADBEEF; resp_vld at N+3, resp_err=0, addr_upd_vld=0.
2. Read with 3 wait states: addr=0x80, prdata=0x12345678 on the pready cycle.
   -> APB signals stable for 4 ACCESS cycles; resp_rdata=0x12345678, resp_vld at N+6, busy high N+1..N+5.
3. Auto-increment wrap, ASIZE=0: addr=0xFC, aincr=1.
   -> addr_upd=0x00 with addr_upd_vld. Repeat with pslverr=1 -> resp_err=1, addr_upd_vld=0.
4. req_vld pulsed in the ACCESS wait state.
   -> busy_err pulse next cycle; only one APB transfer occurs; original address preserved.
5. abort during a 2-wait-state read.
   -> transfer completes on APB; no resp_vld, no addr_upd_vld; resp_rdata keeps its previous value.
6. drst asserted during ACCESS, then back-to-back requests after release.
   -> all outputs 0 the next cycle; subsequent requests complete at 3-cycle intervals.

Source files
------------

// File: rtl/twowire_dtm_bus_master.sv
// Downstream APB3 bus-access engine for the Two-Wire Debug DTM: runs one
// read/write per request and reports data, error status and the post-increment address.
module twowire_dtm_bus_master #(
    parameter  int ASIZE  = 0,
    localparam int W_ADDR = 8 * (1 + ASIZE)
) (
    input  logic              dck,
    input  logic              drst,
    input  logic              req_vld,
    input  logic              req_write,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              aincr,
    input  logic              abort,
    output logic              busy,
    output logic              busy_err,
    output logic              resp_vld,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              addr_upd_vld,
    output logic [W_ADDR-1:0] addr_upd,
    output logic [W_ADDR-1:0] dst_paddr,
    output logic              dst_psel,
    output logic              dst_penable,
    output logic              dst_pwrite,
    output logic [31:0]       dst_pwdata,
    input  logic              dst_pready,
    input  logic              dst_pslverr,
    input  logic [31:0]       dst_prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state;
    logic   aincr_q;
    logic   abort_pend;

    assign busy = (state != IDLE);

    // The APB address/direction registers double as the captured request,
    // so they stay stable from SETUP through every ACCESS wait state.
    always_ff @(posedge dck) begin
        if (drst) begin
            state        <= IDLE;
            aincr_q      <= 1'b0;
            abort_pend   <= 1'b0;
            busy_err     <= 1'b0;
            resp_vld     <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            addr_upd_vld <= 1'b0;
            addr_upd     <= '0;
            dst_paddr    <= '0;
            dst_psel     <= 1'b0;
            dst_penable  <= 1'b0;
            dst_pwrite   <= 1'b0;
            dst_pwdata   <= '0;
        end else begin
            busy_err     <= req_vld && (state != IDLE);
            resp_vld     <= 1'b0;
            resp_err     <= 1'b0;
            addr_upd_vld <= 1'b0;
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (req_vld && !abort) begin
                        state       <= SETUP;
                        aincr_q     <= aincr;
                        dst_psel    <= 1'b1;
                        dst_penable <= 1'b0;
                        dst_paddr   <= req_addr;
                        dst_pwrite  <= req_write;
                        dst_pwdata  <= req_write ? req_wdata : 32'h0;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    dst_penable <= 1'b1;
                    if (abort) abort_pend <= 1'b1;
                end
                ACCESS: begin
                    if (dst_pready) begin
                        state       <= IDLE;
                        dst_psel    <= 1'b0;
                        dst_penable <= 1'b0;
                        abort_pend  <= 1'b0;
                        // An abandoned transfer still finishes on APB but leaves no trace upstream.
                        if (!(abort_pend || abort)) begin
                            resp_vld <= 1'b1;
                            resp_err <= dst_pslverr;
                            if (!dst_pwrite) resp_rdata <= dst_prdata;
                            if (aincr_q && !dst_pslverr) begin
                                addr_upd_vld <= 1'b1;
                                addr_upd     <= dst_paddr + W_ADDR'(4);
                            end
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twowire_dtm_bus_master.sv
// Scoreboard bench for twowire_dtm_bus_master: queued transactions drive an
// APB slave model and supply the expected response for each completion.
module tb_twowire_dtm_bus_master;

    localparam int W_ADDR = 8;

    typedef struct {
        logic              write;
        logic [W_ADDR-1:0] addr;
        logic [31:0]       wdata;
        logic              aincr;
        int                waits;
        logic [31:0]       prdata;
        logic              slverr;
        logic              abrt;
        int                req_cyc;
    } txn_t;

    logic              dck = 1'b0;
    logic              drst = 1'b1;
    logic              req_vld = 1'b0;
    logic              req_write = 1'b0;
    logic [W_ADDR-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              aincr = 1'b0;
    logic              abort = 1'b0;
    logic              busy, busy_err, resp_vld, resp_err, addr_upd_vld;
    logic [31:0]       resp_rdata;
    logic [W_ADDR-1:0] addr_upd, dst_paddr;
    logic              dst_psel, dst_penable, dst_pwrite;
    logic [31:0]       dst_pwdata;
    logic              dst_pready = 1'b0;
    logic              dst_pslverr = 1'b0;
    logic [31:0]       dst_prdata = '0;

    twowire_dtm_bus_master #(.ASIZE(0)) dut (
        .dck(dck), .drst(drst), .req_vld(req_vld), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .aincr(aincr), .abort(abort),
        .busy(busy), .busy_err(busy_err), .resp_vld(resp_vld), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .addr_upd_vld(addr_upd_vld), .addr_upd(addr_upd),
        .dst_paddr(dst_paddr), .dst_psel(dst_psel), .dst_penable(dst_penable),
        .dst_pwrite(dst_pwrite), .dst_pwdata(dst_pwdata), .dst_pready(dst_pready),
        .dst_pslverr(dst_pslverr), .dst_prdata(dst_prdata)
    );

    always #5 dck = ~dck;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          berr_cyc = -1;
    int          wcnt = 0;
    int          xfers = 0;
    bit          mon_en = 1'b0;
    bit          due = 1'b0;
    bit          inflight;
    txn_t        due_t;
    txn_t        q[$];
    logic [31:0] model_rdata = '0;

    always @(posedge dck) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, act, exp);
        end
    endtask

    // Response checking first, then the APB slave answers the transfer at the queue head.
    always @(negedge dck) begin
        if (mon_en && !drst) begin
            if (due) begin
                checkOutput("resp_vld", 32'(resp_vld), 32'(!due_t.abrt));
                checkOutput("addr_upd_vld", 32'(addr_upd_vld),
                            32'(!due_t.abrt && due_t.aincr && !due_t.slverr));
                if (!due_t.abrt) begin
                    checkOutput("resp_err", 32'(resp_err), 32'(due_t.slverr));
                    checkOutput("resp_latency", 32'(cyc), 32'(due_t.req_cyc + 3 + due_t.waits));
                    if (due_t.aincr && !due_t.slverr)
                        checkOutput("addr_upd", 32'(addr_upd), 32'(W_ADDR'(due_t.addr + 8'd4)));
                    if (!due_t.write) model_rdata = due_t.prdata;
                end
                due = 1'b0;
            end else begin
                checkOutput("resp_vld_idle", 32'(resp_vld), 32'd0);
                checkOutput("addr_upd_vld_idle", 32'(addr_upd_vld), 32'd0);
            end
            checkOutput("resp_rdata", resp_rdata, model_rdata);
            checkOutput("busy_err", 32'(busy_err), 32'(cyc == berr_cyc));

            inflight = (q.size() > 0) && (q[0].req_cyc < cyc);
            checkOutput("busy", 32'(busy), 32'(inflight));
            checkOutput("psel", 32'(dst_psel), 32'(inflight));
            dst_pready  = 1'b0;
            dst_prdata  = $urandom;
            dst_pslverr = 1'($urandom_range(0, 1));
            if (inflight) begin
                checkOutput("penable", 32'(dst_penable), 32'(cyc != q[0].req_cyc + 1));
                checkOutput("paddr", 32'(dst_paddr), 32'(q[0].addr));
                checkOutput("pwrite", 32'(dst_pwrite), 32'(q[0].write));
                checkOutput("pwdata", dst_pwdata, q[0].write ? q[0].wdata : 32'h0);
                if (dst_penable) begin
                    if (wcnt == q[0].waits) begin
                        dst_pready  = 1'b1;
                        dst_prdata  = q[0].prdata;
                        dst_pslverr = q[0].slverr;
                        due_t = q.pop_front();
                        due   = 1'b1;
                        wcnt  = 0;
                        xfers++;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                wcnt = 0;
            end
        end else begin
            dst_pready = 1'b0;
            wcnt = 0;
        end
    end

    task automatic nextCycle();
        @(posedge dck);
        #1;
    endtask

    task automatic applyStimulus(input logic write, input logic [W_ADDR-1:0] addr,
                                 input logic [31:0] wdata, input logic inc, input int waits,
                                 input logic [31:0] prdata, input logic slverr, input logic abrt);
        txn_t t;
        t.write = write; t.addr = addr; t.wdata = wdata; t.aincr = inc; t.waits = waits;
        t.prdata = prdata; t.slverr = slverr; t.abrt = abrt; t.req_cyc = cyc;
        q.push_back(t);
        req_vld = 1'b1; req_write = write; req_addr = addr; req_wdata = wdata; aincr = inc;
        nextCycle();
        req_vld = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; aincr = 1'b0;
    endtask

    // A request the DUT must drop (busy, or paired with abort in IDLE): nothing queued.
    task automatic pokeRequest(input logic [W_ADDR-1:0] addr, input logic with_abort);
        req_vld = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = 32'hBAD0BAD0;
        abort = with_abort;
        nextCycle();
        req_vld = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; abort = 1'b0;
    endtask

    task automatic pulseAbort();
        abort = 1'b1;
        nextCycle();
        abort = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while ((q.size() != 0 || due) && n < limit) begin
            nextCycle();
            n++;
        end
        if (q.size() != 0 || due) begin
            checkOutput("idle_timeout", 32'd0, 32'd1);
            q.delete();
            due = 1'b0;
        end
        nextCycle();
    endtask

    task automatic checkResetState();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_busy_err", 32'(busy_err), 32'd0);
        checkOutput("rst_resp_vld", 32'(resp_vld), 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_addr_upd_vld", 32'(addr_upd_vld), 32'd0);
        checkOutput("rst_addr_upd", 32'(addr_upd), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_psel", 32'(dst_psel), 32'd0);
        checkOutput("rst_penable", 32'(dst_penable), 32'd0);
        checkOutput("rst_pwrite", 32'(dst_pwrite), 32'd0);
        checkOutput("rst_paddr", 32'(dst_paddr), 32'd0);
        checkOutput("rst_pwdata", dst_pwdata, 32'd0);
    endtask

    initial begin
        int xf0;
        int c0;
        repeat (3) nextCycle();
        drst = 1'b0;
        checkResetState();
        mon_en = 1'b1;
        nextCycle();

        // Zero-wait write, then a read with three wait states.
        applyStimulus(1'b1, 8'h40, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        waitIdle(20);
        applyStimulus(1'b0, 8'h80, 32'h0, 1'b0, 3, 32'h12345678, 1'b0, 1'b0);
        waitIdle(20);

        // Increment wraps past the top of the 8-bit space; an error suppresses the update.
        applyStimulus(1'b0, 8'hFC, 32'h0, 1'b1, 0, 32'hCAFEF00D, 1'b0, 1'b0);
        waitIdle(20);
        applyStimulus(1'b1, 8'hFE, 32'h55AA55AA, 1'b1, 1, 32'h0, 1'b1, 1'b0);
        waitIdle(20);

        // Stray request during an ACCESS wait state.
        xf0 = xfers;
        applyStimulus(1'b0, 8'h24, 32'h0, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 1'b0);
        nextCycle();
        berr_cyc = cyc + 1;
        pokeRequest(8'h99, 1'b0);
        waitIdle(20);
        checkOutput("single_xfer", 32'(xfers), 32'(xf0 + 1));

        // Abort mid-read: APB completes but nothing is reported.
        xf0 = xfers;
        applyStimulus(1'b0, 8'h10, 32'h0, 1'b1, 2, 32'h0BADCAFE, 1'b0, 1'b1);
        nextCycle();
        pulseAbort();
        waitIdle(20);
        checkOutput("abort_xfer", 32'(xfers), 32'(xf0 + 1));

        // Abort alone in IDLE does nothing; abort with a request drops it.
        xf0 = xfers;
        pulseAbort();
        pokeRequest(8'h44, 1'b1);
        repeat (4) nextCycle();
        checkOutput("abort_idle_xfer", 32'(xfers), 32'(xf0));
        applyStimulus(1'b0, 8'h48, 32'h0, 1'b0, 0, 32'h13572468, 1'b0, 1'b0);
        waitIdle(20);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), W_ADDR'($urandom), $urandom,
                          1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom,
                          1'($urandom_range(0, 1)), 1'b0);
            waitIdle(20);
        end

        // Reset in the middle of a long ACCESS, then back-to-back requests.
        applyStimulus(1'b0, 8'h60, 32'h0, 1'b1, 10, 32'h77777777, 1'b0, 1'b0);
        repeat (3) nextCycle();
        drst = 1'b1;
        q.delete();
        due = 1'b0;
        model_rdata = '0;
        berr_cyc = -1;
        nextCycle();
        drst = 1'b0;
        checkResetState();
        for (int i = 0; i < 4; i++) begin
            c0 = cyc;
            applyStimulus(1'(i % 2), W_ADDR'(8'h04 * (i + 1)), 32'h1000_0000 + 32'(i),
                          1'b1, 0, 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
            nextCycle();
            nextCycle();
            checkOutput("b2b_interval", 32'(cyc - c0), 32'd3);
        end
        waitIdle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
